// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and the
// baud divisor helper, so the transmitter and receiver agree on them.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Integer-truncated clocks per bit; callers guarantee the result is >= 2.
  function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the UART transmitter. The ready flag is registered
// from the next-cycle occupancy so it is low exactly while the FIFO is full.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic                     ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);
  assign dout    = mem[rd_ptr];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ready   <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q <= count_d;
      ready   <= (count_d != CW'(DEPTH));
    end
  end

endmodule

// File: rtl/uart_transmitter_cfg.sv
// Configurable UART transmitter: FIFO-fed framer with selectable data width,
// parity and stop bits; frames run back-to-back while words are queued.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_IDLE   | line idle high, waiting for a queued word
//   ST_START  | driving the start bit (0)
//   ST_DATA   | shifting data bits out, LSB first
//   ST_PARITY | driving the parity bit (only when parity is enabled)
//   ST_STOP   | driving stop bit(s); chains straight into the next frame
module uart_transmitter_cfg
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 921600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_pin,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CPB = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
    $error("uart_transmitter_cfg: PARITY must be 0 (none), 1 (odd) or 2 (even)");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_transmitter_cfg: DATA_BITS must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_transmitter_cfg: STOP_BITS must be 1 or 2");
  end
  if (CPB < 2) begin : g_bad_divisor
    $error("uart_transmitter_cfg: CLOCK_FREQ / BAUD_RATE must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_transmitter_cfg: FIFO_DEPTH must be a power of two >= 2");
  end

  tx_state_t            state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 pin_d;
  logic                 baud_done;
  logic                 start_frame;
  logic                 pop;
  logic                 push;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;

  function automatic logic frame_parity(input logic [DATA_BITS-1:0] w);
    return (PARITY == PAR_ODD) ? ~^w : ^w;
  endfunction

  assign push = tx_valid && tx_ready && !fifo_full;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (tx_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .ready (tx_ready),
    .count (fifo_count)
  );

  assign baud_done = (baud_q == BAUD_LAST);

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_d       = par_q;
    start_frame = 1'b0;
    pop         = 1'b0;
    pin_d       = 1'b1;

    if (state_q != ST_IDLE) begin
      baud_d = baud_done ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        start_frame = !fifo_empty;
      end
      ST_START: begin
        if (baud_done) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_d   = bit_q + 4'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_done) begin
          state_d = ST_STOP;
          bit_d   = '0;
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          if (bit_q == STOP_LAST) begin
            // Pop on the last stop clock so the next start bit follows with no gap.
            start_frame = !fifo_empty;
            state_d     = ST_IDLE;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_frame) begin
      pop     = 1'b1;
      state_d = ST_START;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = fifo_dout;
      par_d   = frame_parity(fifo_dout);
    end

    case (state_d)
      ST_START:  pin_d = 1'b0;
      ST_DATA:   pin_d = shift_d[0];
      ST_PARITY: pin_d = par_d;
      default:   pin_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_pin  <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_pin  <= pin_d;
      tx_busy <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_transmitter_cfg.sv
// Directed bench for uart_transmitter_cfg: 8N1, 8E1 and 7O2 instances checked
// clock-by-clock against hand-built frame patterns.
module tb_uart_transmitter_cfg;

  localparam int CPB = 54;

  logic       clk;
  logic       rst;

  logic [7:0] tx_data0, tx_data1;
  logic [6:0] tx_data2;
  logic       tx_valid0, tx_valid1, tx_valid2;
  logic       tx_ready0, tx_ready1, tx_ready2;
  logic       tx_pin0, tx_pin1, tx_pin2;
  logic       tx_busy0, tx_busy1, tx_busy2;
  logic [2:0] fifo_count0, fifo_count1, fifo_count2;

  int n_chk;
  int n_bad;

  logic [7:0] fill_w [6] = '{8'h3C, 8'hA5, 8'h0F, 8'hF0, 8'h81, 8'h7E};
  int         acc_cyc [6];
  int         k;
  bit         full_seen;

  uart_transmitter_cfg u_dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .tx_pin(tx_pin0), .tx_busy(tx_busy0), .fifo_count(fifo_count0)
  );

  uart_transmitter_cfg #(.PARITY(2)) u_dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .tx_pin(tx_pin1), .tx_busy(tx_busy1), .fifo_count(fifo_count1)
  );

  uart_transmitter_cfg #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx_pin(tx_pin2), .tx_busy(tx_busy2), .fifo_count(fifo_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic pin_of(input int sel);
    case (sel)
      0:       return tx_pin0;
      1:       return tx_pin1;
      default: return tx_pin2;
    endcase
  endfunction

  task automatic send(input int sel, input logic [8:0] d);
    @(negedge clk);
    case (sel)
      0:       begin tx_data0 = d[7:0]; tx_valid0 = 1'b1; end
      1:       begin tx_data1 = d[7:0]; tx_valid1 = 1'b1; end
      default: begin tx_data2 = d[6:0]; tx_valid2 = 1'b1; end
    endcase
    @(posedge clk);
    @(negedge clk);
    tx_valid0 = 1'b0;
    tx_valid1 = 1'b0;
    tx_valid2 = 1'b0;
  endtask

  // Starts sampling at the first negedge after the pop edge; bits[0] is the start bit.
  task automatic check_frame(input string tag, input int sel, input logic [31:0] bits,
                             input int nbits);
    for (int b = 0; b < nbits; b++) begin
      int wrong;
      wrong = 0;
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (pin_of(sel) !== bits[b]) wrong++;
      end
      chk($sformatf("%s bit%0d wrong_clks", tag, b), wrong, 0);
    end
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst = 1'b0;
    tx_valid0 = 1'b0; tx_valid1 = 1'b0; tx_valid2 = 1'b0;
    tx_data0 = '0; tx_data1 = '0; tx_data2 = '0;
    full_seen = 1'b0;
    for (int i = 0; i < 6; i++) acc_cyc[i] = -1;

    repeat (3) @(negedge clk);
    chk("reset tx_pin", tx_pin0, 1'b1);
    chk("reset tx_busy", tx_busy0, 1'b0);
    chk("reset tx_ready", tx_ready0, 1'b0);
    chk("reset fifo_count", fifo_count0, 3'd0);
    chk("reset tx_pin 7o2", tx_pin2, 1'b1);

    rst = 1'b1;
    #1;
    chk("release ready before edge", tx_ready0, 1'b0);
    @(posedge clk);
    #1;
    chk("release ready after edge", tx_ready0, 1'b1);

    // 8N1 single frame, 0x55
    send(0, 9'h55);
    check_frame("8n1", 0, 32'b1010101010, 10);
    chk("8n1 busy last clk", tx_busy0, 1'b1);
    @(negedge clk);
    chk("8n1 busy fallen", tx_busy0, 1'b0);
    chk("8n1 idle pin", tx_pin0, 1'b1);

    // 8E1, 0xA2
    send(1, 9'hA2);
    check_frame("8e1", 1, 32'b11101000100, 11);
    chk("8e1 busy last clk", tx_busy1, 1'b1);
    @(negedge clk);
    chk("8e1 busy fallen", tx_busy1, 1'b0);

    // Back-to-back 0xAA then 0xA2 five clocks later
    send(0, 9'hAA);
    fork
      check_frame("b2b", 0, 32'b11010001001101010100, 20);
      begin
        repeat (3) @(negedge clk);
        send(0, 9'hA2);
      end
    join
    @(negedge clk);
    chk("b2b busy fallen", tx_busy0, 1'b0);
    chk("b2b fifo empty", fifo_count0, 3'd0);

    // FIFO fill: six words offered continuously
    @(negedge clk);
    tx_data0 = fill_w[0];
    tx_valid0 = 1'b1;
    k = 0;
    fork
      begin
        for (int cyc = 0; cyc < 700 && k < 6; cyc++) begin
          logic rdy;
          rdy = tx_ready0;
          @(posedge clk);
          if (rdy) begin
            acc_cyc[k] = cyc;
            k++;
          end
          @(negedge clk);
          if (k == 5 && !full_seen) begin
            full_seen = 1'b1;
            chk("fill ready when full", tx_ready0, 1'b0);
            chk("fill count when full", fifo_count0, 3'd4);
          end
          if (k < 6) tx_data0 = fill_w[k];
        end
        tx_valid0 = 1'b0;
      end
      begin
        logic [9:0] fr;
        repeat (29) @(negedge clk);
        for (int j = 0; j < 6; j++) begin
          for (int b = 0; b < 10; b++) begin
            fr[b] = tx_pin0;
            repeat (CPB) @(negedge clk);
          end
          chk($sformatf("fill frame%0d", j), fr, {1'b1, fill_w[j], 1'b0});
        end
      end
    join
    chk("fill words accepted", k, 6);
    for (int i = 0; i < 5; i++) chk($sformatf("fill accept cycle%0d", i), acc_cyc[i], i);
    chk("fill accept cycle5", acc_cyc[5], 542);
    chk("fill drained busy", tx_busy0, 1'b0);
    chk("fill drained count", fifo_count0, 3'd0);

    // 7O2, 0x41
    send(2, 9'h41);
    check_frame("7o2", 2, 32'b11110000010, 11);
    chk("7o2 busy last clk", tx_busy2, 1'b1);
    @(negedge clk);
    chk("7o2 busy fallen", tx_busy2, 1'b0);

    // Reset during data bit 3 with a second word queued
    send(0, 9'h55);
    send(0, 9'h33);
    repeat (240) @(negedge clk);
    chk("midrst pin before", tx_pin0, 1'b0);
    chk("midrst count before", fifo_count0, 3'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst pin", tx_pin0, 1'b1);
    chk("midrst count", fifo_count0, 3'd0);
    chk("midrst busy", tx_busy0, 1'b0);
    chk("midrst ready", tx_ready0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst ready after release", tx_ready0, 1'b1);
    send(0, 9'h55);
    check_frame("post-rst", 0, 32'b1010101010, 10);
    @(negedge clk);
    chk("post-rst busy fallen", tx_busy0, 1'b0);
    chk("post-rst count", fifo_count0, 3'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_transmitter_cfg.md
# uart_transmitter_cfg

Parametrised successor to the current fixed 8N1 UART transmitter. It serialises words from a small internal FIFO onto `tx_pin`, with configurable data width, parity and stop bits. Frames go out back-to-back with no idle gap while the FIFO holds data, so a producer can queue a new word mid-frame without corrupting the frame in flight. It sits between a byte/word producer (CPU bridge, debug streamer) and the board TX pin.

## Interface
- `CLOCK_FREQ`, 50_000_000: input clock frequency, Hz.
- `BAUD_RATE`, 921600: line rate, bit/s. Divisor `CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE`, integer-truncated (54 at defaults). Must be ≥ 2.
- `DATA_BITS`, 8: data bits per frame, legal 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even. Other values are illegal and trip an elaboration-time check.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: FIFO entries, a power of two ≥ 2.
- `clk  input  1`: single clock. All logic is rising-edge.
- `rst  input  1`: reset, asynchronous, active-low. Asserted when 0.
- `tx_data  input  DATA_BITS`: word to queue.
- `tx_valid  input  1`: producer has a word on `tx_data`.
- `tx_ready  output  1`: the FIFO can accept a word this cycle. Registered.
- `tx_pin  output  1`: serial line, idle high. Registered.
- `tx_busy  output  1`: a frame is in progress (state ≠ IDLE). Registered.
- `fifo_count  output  $clog2(FIFO_DEPTH)+1`: current FIFO occupancy.

## Operation
- **Accept.** A word is accepted on a rising edge where `tx_valid && tx_ready`. The producer may hold `tx_valid` high across several cycles, and each such cycle accepts a further word. Words presented while `tx_ready` is low are ignored.
- **Frame format.** Each frame is sent in this order:
  - start bit (0);
  - data bits, LSB first;
  - optional parity bit: XOR of the data bits for even parity, its inverse for odd parity;
  - `STOP_BITS` stop bits (1).
- **State machine** (states: IDLE, START, DATA, PARITY, STOP):
  - IDLE → START when the FIFO is non-empty. The FIFO is popped on this edge and the word loaded into the shift register.
  - START → DATA after `CLKS_PER_BIT` clocks.
  - DATA → PARITY, or → STOP if parity is off, after `DATA_BITS` bit periods.
  - PARITY → STOP after 1 bit period.
  - STOP → START if the FIFO is non-empty at the final clock of the last stop bit; that edge pops the FIFO, giving zero idle between frames. Otherwise STOP → IDLE.
- **Counters.** The baud counter counts 0..`CLKS_PER_BIT`-1 and wraps. The bit counter counts data bits and stop bits.
- **Simultaneous push and pop.** If a push and a pop land on the same edge, `fifo_count` is unchanged and both the write pointer and the read pointer advance. The pointers wrap modulo `FIFO_DEPTH`.
- **Full FIFO.** While the FIFO is full, `tx_ready` is 0. A pop frees space, and `tx_ready` returns to 1 on the following edge.
- **Reset mid-frame.** Reset takes effect immediately:
  - `tx_pin` goes to 1 and the frame is aborted; no partial-frame completion.
  - The FIFO is flushed and `fifo_count` returns to 0.

## Timing
- **Reset values:**
  - `tx_pin` = 1
  - `tx_busy` = 0
  - `tx_ready` = 0
  - `fifo_count` = 0
  - state = IDLE
- **After reset release.** `tx_ready` rises on the first rising edge after `rst` goes high.
- **Latency into an empty, idle block.** Word accepted at edge N → FIFO pop at edge N+1 → `tx_pin` low and `tx_busy` high from N+1.
- **Bit period.** Each bit holds exactly `CLKS_PER_BIT` clocks.
- **Frame length.** (1 + `DATA_BITS` + (`PARITY`≠0) + `STOP_BITS`) × `CLKS_PER_BIT` clocks.
- **`tx_ready` timing.** `tx_ready` is registered from the next-cycle occupancy, so it is 0 in exactly the cycles where `fifo_count` == `FIFO_DEPTH`.

## Structure
- **Shared package `uart_pkg`.** Holds:
  - parity-mode constants `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`;
  - the state encoding;
  - a `clks_per_bit` function, reused by the future receiver.
- **Sub-module `uart_tx_fifo`.** Synchronous FIFO parametrised by width and depth, with push/pop, full/empty and count outputs, on the same `clk`/`rst`.
- **Top level.** The state machine, baud counter, shift register and parity generator live in `uart_transmitter_cfg`.

## Test plan
- **Single frame, defaults (8N1, 54 clk/bit).** Write 0x55 → `tx_pin` shows 0,1,0,1,0,1,0,1,0,1, each level held 54 clocks. The start bit begins 1 clock after the accept edge. `tx_busy` falls after 540 clocks.
- **Even parity, 8E1.** Write 0xA2 → data bits 0,1,0,0,0,1,0,1, then parity 1, then stop bit 1. The frame is 11 bit times.
- **Back-to-back.** Write 0xAA, then 0xA2 five clocks later → both words accepted. The 0xA2 start bit immediately follows the 0xAA stop bit with zero idle clocks. Total 20 bit times.
- **FIFO full (depth 4).** Hold `tx_valid` with 6 words → five words accepted on consecutive edges, after which `tx_ready` = 0 and `fifo_count` = 4. The sixth word is accepted the edge after the first frame's final stop-bit pop.
- **7O2, `DATA_BITS`=7, odd parity.** Write 0x41 → data bits 1,0,0,0,0,0,1, parity 1, two stop bits. The frame is 11 bit times.
- **Reset mid-frame.** Assert `rst` low during data bit 3 → `tx_pin` = 1 and `fifo_count` = 0 with no clock edge. After release, a new 0x55 write transmits correctly.
